// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-outstanding memory port between the instruction-fetch
// port (if_*) and the load/store port (dm_*). Data requests normally win;
// a starvation counter forces a fetch grant after STARVE_LIMIT consecutive
// data grants taken while a fetch was waiting. A fetch cancelled by if_kill
// while in flight still completes on the memory side, but its response is
// swallowed.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr/if_kill      fetch request, address, cancel
//   if_rvalid/if_rdata/if_stall fetch response pulse, data, stall
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be              load/store request fields
//   dm_rvalid/dm_rdata/dm_stall load data or store ack, data, stall
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be            memory request (combinational from winner)
//   mem_ready                   memory accepts when mem_req && mem_ready
//   mem_rvalid/mem_rdata        memory response
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_kill,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_stall,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    output logic                    dm_rvalid,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_stall,
    output logic                    mem_req,
    input  logic                    mem_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_starve_cnt;
    logic                 r_drop;
    logic                 r_dm_we;

    logic w_if_cand;
    logic w_grant_i;
    logic w_grant_d;
    logic w_accept;
    logic w_if_rvalid;
    logic w_dm_rvalid;

    // Arbitration: data first, unless the fetch has been starved long enough.
    always_comb begin
        w_if_cand = if_req && !if_kill;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_if_cand && (r_starve_cnt == STARVE_MAX)) begin
                w_grant_i = 1'b1;
            end else if (dm_req) begin
                w_grant_d = 1'b1;
            end else if (w_if_cand) begin
                w_grant_i = 1'b1;
            end else begin
                w_grant_i = 1'b0;
            end
        end else begin
            w_grant_d = 1'b0;
        end
        w_accept = (w_grant_i || w_grant_d) && mem_ready;
        // A kill arriving in the response cycle also suppresses delivery.
        w_if_rvalid = (r_state == ST_WAIT_I) && mem_rvalid && !r_drop && !if_kill;
        w_dm_rvalid = (r_state == ST_WAIT_D) && mem_rvalid;
    end

    // Output drive: request fields from the winner, responses passed through
    // with zero added latency; everything is held at 0 while rst is high.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        if_stall  = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        dm_stall  = 1'b0;
        if (!rst) begin
            if (w_grant_d) begin
                mem_req   = 1'b1;
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
                mem_be    = dm_be;
            end else if (w_grant_i) begin
                mem_req   = 1'b1;
                mem_addr  = if_addr;
                mem_be    = '1;
            end else begin
                mem_req   = 1'b0;
            end
            if_rvalid = w_if_rvalid;
            if_rdata  = w_if_rvalid ? mem_rdata : '0;
            if_stall  = if_req && !w_if_rvalid;
            dm_rvalid = w_dm_rvalid;
            dm_rdata  = (w_dm_rvalid && !r_dm_we) ? mem_rdata : '0;
            dm_stall  = dm_req && !w_dm_rvalid;
        end else begin
            mem_req   = 1'b0;
        end
    end

    // FSM, starvation counter, drop flag and latched store/load kind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_drop       <= 1'b0;
            r_dm_we      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_accept && w_grant_d) begin
                        r_state <= ST_WAIT_D;
                        r_dm_we <= dm_we;
                        if (w_if_cand && (r_starve_cnt != STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + CNT_WIDTH'(1);
                        end else begin
                            r_starve_cnt <= r_starve_cnt;
                        end
                    end else if (w_accept && w_grant_i) begin
                        r_state      <= ST_WAIT_I;
                        r_starve_cnt <= '0;
                        // A fetch only wins without if_kill, so this normally
                        // loads 0; it keeps the accept-cycle kill rule local.
                        r_drop       <= if_kill;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_I: begin
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                        r_drop  <= 1'b0;
                    end else if (if_kill) begin
                        r_drop <= 1'b1;
                    end else begin
                        r_drop <= r_drop;
                    end
                end
                ST_WAIT_D: begin
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_D;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_drop  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_kill = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_rvalid, if_stall;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] dm_addr = 32'h0, dm_wdata = 32'h0;
    logic [3:0]  dm_be = 4'h0;
    logic        dm_rvalid, dm_stall;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we, mem_rvalid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    // memory model state
    int          lat = 2;
    logic [31:0] next_rdata = 32'h0;
    logic        force_rv = 1'b0;
    logic        model_rv = 1'b0;
    logic [31:0] model_rdata = 32'h0;
    int          rv_cnt = 0;
    int          acc_cnt = 0;
    txn_t        acc_log [0:63];

    // scoreboard / counters
    txn_t exp_q[$];
    int   seen = 0;
    int   checks = 0;
    int   failures = 0;

    assign mem_rvalid = model_rv | force_rv;
    assign mem_rdata  = model_rdata;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: logs accepted requests, answers 'lat' cycles after acceptance.
    always @(posedge clk) begin
        model_rv <= 1'b0;
        if (rv_cnt != 0) begin
            rv_cnt <= rv_cnt - 1;
            if (rv_cnt == 1) model_rv <= 1'b1;
        end else if (mem_req && mem_ready) begin
            acc_log[acc_cnt[5:0]] <= {mem_we, mem_addr, mem_wdata, mem_be};
            acc_cnt     <= acc_cnt + 1;
            model_rdata <= next_rdata;
            if (lat == 1) model_rv <= 1'b1;
            else          rv_cnt   <= lat - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be);
        txn_t t;
        t = {we, addr, wd, be};
        exp_q.push_back(t);
    endtask

    // Pop one expectation per accepted memory request and compare in order.
    task automatic sb_drain(input string tag);
        txn_t a, e;
        while (seen < acc_cnt) begin
            a = acc_log[seen[5:0]];
            chk({tag, "_pending"}, 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_we"}, a.we, e.we);
                chk({tag, "_addr"}, a.addr, e.addr);
                chk({tag, "_be"}, a.be, e.be);
                if (e.we) chk({tag, "_wdata"}, a.wdata, e.wdata);
            end
            seen++;
        end
    endtask

    task automatic wait_rv(input bit want_i, output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); #1;
            if ((want_i && if_rvalid) || (!want_i && dm_rvalid)) begin
                n = k;
                break;
            end
        end
        chk(want_i ? "if_rvalid_seen" : "dm_rvalid_seen", 64'(n != 0), 64'd1);
    endtask

    function automatic logic any_out();
        return |{mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rvalid, if_rdata,
                 if_stall, dm_rvalid, dm_rdata, dm_stall};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nd, ni;
        // ---- reset: requests present but everything must read 0
        @(negedge clk); if_req = 1'b1; dm_req = 1'b1; #1;
        chk("rst_outputs", any_out(), 1'b0);
        @(negedge clk); #1;
        chk("rst_outputs2", any_out(), 1'b0);
        @(negedge clk); rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; #1;
        chk("post_rst_outputs", any_out(), 1'b0);

        // ---- fetch only
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; lat = 2; next_rdata = 32'h00500093;
        push(1'b0, 32'h100, 32'h0, 4'hF);
        #1;
        chk("f_mem_req", mem_req, 1'b1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", mem_we, 1'b0);
        chk("f_mem_be", mem_be, 4'hF);
        chk("f_stall0", if_stall, 1'b1);
        @(negedge clk); #1;
        chk("f_wait_req", mem_req, 1'b0);
        chk("f_stall1", if_stall, 1'b1);
        chk("f_no_early_rv", if_rvalid, 1'b0);
        wait_rv(1'b1, n);
        chk("f_latency", n, 1);
        chk("f_rdata", if_rdata, 32'h00500093);
        chk("f_stall_done", if_stall, 1'b0);
        if_req = 1'b0;
        @(negedge clk); #1;
        chk("f_pulse", if_rvalid, 1'b0);
        chk("f_rdata_zero", if_rdata, 32'h0);
        sb_drain("sb_fetch");

        // ---- simultaneous fetch and load
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_be = 4'hF;
        lat = 2; next_rdata = 32'h11223344;
        push(1'b0, 32'h2000, 32'h0, 4'hF);
        push(1'b0, 32'h104, 32'h0, 4'hF);
        #1;
        chk("s_data_first", mem_addr, 32'h2000);
        wait_rv(1'b0, n);
        chk("s_d_latency", n, 2);
        chk("s_d_rdata", dm_rdata, 32'h11223344);
        chk("s_if_stall", if_stall, 1'b1);
        dm_req = 1'b0; next_rdata = 32'h00A00113;
        @(negedge clk); #1;
        chk("s_fetch_req", mem_req, 1'b1);
        chk("s_fetch_addr", mem_addr, 32'h104);
        wait_rv(1'b1, n);
        chk("s_f_rdata", if_rdata, 32'h00A00113);
        if_req = 1'b0;
        sb_drain("sb_simul");

        // ---- starvation: 4 data grants, fetch, data again
        @(negedge clk);
        lat = 1; next_rdata = 32'h77;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h200;
        for (int k = 0; k < 4; k++) push(1'b0, 32'h3000, 32'h0, 4'hF);
        push(1'b0, 32'h200, 32'h0, 4'hF);
        push(1'b0, 32'h3000, 32'h0, 4'hF);
        nd = 0; ni = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if (dm_rvalid) begin
                nd++;
                if (nd == 4) chk("st_cnt_sat", dut.r_starve_cnt, 3'd4);
                if (nd == 5) dm_req = 1'b0;
            end
            if (if_rvalid) begin
                ni++;
                if_req = 1'b0;
                chk("st_cnt_clear", dut.r_starve_cnt, 3'd0);
                chk("st_fetch_after4", nd, 4);
            end
            if (nd == 5) break;
        end
        chk("st_data_cnt", nd, 5);
        chk("st_fetch_cnt", ni, 1);
        sb_drain("sb_starve");

        // ---- kill in WAIT_I, then store granted right after
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300; lat = 3; next_rdata = 32'h55;
        push(1'b0, 32'h300, 32'h0, 4'hF);
        #1;
        chk("k_grant", mem_addr, 32'h300);
        @(negedge clk); if_kill = 1'b1; #1;
        chk("k_rv0", if_rvalid, 1'b0);
        @(negedge clk); if_kill = 1'b0; if_req = 1'b0; #1;
        chk("k_rv1", if_rvalid, 1'b0);
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h4000; dm_wdata = 32'hDEADBEEF;
        dm_be = 4'b0011; next_rdata = 32'hCAFEF00D;
        push(1'b1, 32'h4000, 32'hDEADBEEF, 4'b0011);
        #1;
        chk("k_resp_now", mem_rvalid, 1'b1);
        chk("k_rv_dropped", if_rvalid, 1'b0);
        chk("k_no_grant_return", mem_req, 1'b0);
        lat = 1;
        @(negedge clk); if_kill = 1'b1; #1;
        chk("w_mem_req", mem_req, 1'b1);
        chk("w_mem_we", mem_we, 1'b1);
        chk("w_mem_be", mem_be, 4'b0011);
        chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
        wait_rv(1'b0, n);
        chk("w_latency", n, 1);
        chk("w_rdata_zero", dm_rdata, 32'h0);
        dm_req = 1'b0; dm_we = 1'b0; if_kill = 1'b0;
        sb_drain("sb_kill_store");

        // ---- reset in WAIT_D, late response, then mem_ready stall
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 32'h5000; dm_be = 4'hF; lat = 3; next_rdata = 32'h99;
        push(1'b0, 32'h5000, 32'h0, 4'hF);
        #1;
        chk("r_grant", mem_addr, 32'h5000);
        @(negedge clk); rst = 1'b1; #1;
        chk("r_rst_outputs", any_out(), 1'b0);
        @(negedge clk); rst = 1'b0; dm_req = 1'b0; #1;
        chk("r_after_outputs", any_out(), 1'b0);
        @(negedge clk); #1;
        chk("r_late_resp", mem_rvalid, 1'b1);
        chk("r_late_ignored", any_out(), 1'b0);
        @(negedge clk);
        mem_ready = 1'b0; dm_req = 1'b1; dm_addr = 32'h6000; lat = 2;
        next_rdata = 32'h0BADF00D;
        push(1'b0, 32'h6000, 32'h0, 4'hF);
        #1;
        chk("r_stall_req", mem_req, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("r_stall_hold", mem_req, 1'b1);
            chk("r_stall_addr", mem_addr, 32'h6000);
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("r_accept_req", mem_req, 1'b1);
        wait_rv(1'b0, n);
        chk("r_rdata", dm_rdata, 32'h0BADF00D);
        dm_req = 1'b0;
        sb_drain("sb_reset");

        @(negedge clk); #1;
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants tolerated while fetch waits.
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high. Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held with stable if_addr until if_rvalid or if_kill
- if_addr  in  ADDR_WIDTH  fetch address
- if_kill  in  1  fetch cancel (taken branch, PCSrcE)
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  DATA_WIDTH  fetch data
- if_stall  out  1  if_req && !if_rvalid
- dm_req  in  1  load/store request; held with stable fields until dm_rvalid
- dm_we  in  1  1 = store
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_be  in  DATA_WIDTH/8  byte enables
- dm_rvalid  out  1  load data or store ack, one-cycle pulse
- dm_rdata  out  DATA_WIDTH  load data
- dm_stall  out  1  dm_req && !dm_rvalid
- mem_req  out  1  memory request
- mem_ready  in  1  memory accepts when mem_req && mem_ready
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  request fields
- mem_rvalid  in  1  response for accepted request (reads and writes)
- mem_rdata  in  DATA_WIDTH  read data

Function
REQ-005 FSM states SHALL be IDLE, WAIT_I, WAIT_D; at most one memory transaction outstanding.
REQ-006 In IDLE, candidate fetch = if_req && !if_kill; the winner SHALL be data if dm_req, else fetch, except fetch wins when starve_cnt == STARVE_LIMIT and the fetch candidate is present.
REQ-007 In IDLE with a winner, mem_req SHALL be 1 and mem_* fields SHALL be driven combinationally from the winner (fetch: mem_we=0, mem_be all ones); otherwise mem_req=0 and fields 0.
REQ-008 On acceptance (mem_req && mem_ready) the FSM SHALL move to WAIT_I or WAIT_D next cycle; without mem_ready it SHALL stay IDLE and re-arbitrate next cycle.
REQ-009 In WAIT_x mem_req SHALL be 0; on mem_rvalid the FSM SHALL return to IDLE and pulse x_rvalid in that same cycle (zero added latency); the returning cycle SHALL NOT start a new grant.
REQ-010 dm_rdata SHALL equal mem_rdata when dm_rvalid and the latched transaction was a load, else 0; if_rdata SHALL equal mem_rdata when if_rvalid, else 0.
REQ-011 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, on each data acceptance while the fetch candidate is present, and SHALL clear on fetch acceptance.
REQ-012 if_kill asserted in WAIT_I, or in the acceptance cycle of a fetch, SHALL set a drop flag; the matching response SHALL then complete the FSM with if_rvalid held 0; the flag SHALL clear on return to IDLE.
REQ-013 mem_rvalid in IDLE SHALL be ignored.
REQ-014 if_kill SHALL NOT affect data transactions.

Reset
REQ-015 On rst the FSM SHALL enter IDLE, starve_cnt and drop flag SHALL clear, and all outputs SHALL be 0 in the cycle after reset and while rst is high.
REQ-016 Reset mid-transaction SHALL abandon it; a late mem_rvalid after reset SHALL be ignored per REQ-013.

Verification
REQ-017 Fetch only: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid 2 cycles after acceptance with rdata=0x00500093 -> mem_addr=0x100, mem_we=0; if_rvalid one cycle with if_rdata=0x00500093; if_stall=1 until then.
REQ-018 Simultaneous: if_req and dm_req load at 0x2000 -> data granted first, dm_rvalid with mem_rdata, fetch granted in the cycle after dm_rvalid.
REQ-019 Starvation, STARVE_LIMIT=4: dm_req held continuously with if_req=1 -> 4 data grants, then fetch grant, then data resumes; starve_cnt=0 after fetch acceptance.
REQ-020 Kill: fetch accepted, if_kill pulsed in WAIT_I, mem_rvalid 3 cycles later -> if_rvalid stays 0, FSM back to IDLE, next request granted following cycle.
REQ-021 Store: dm_we=1, dm_be=0b0011, dm_wdata=0xDEADBEEF -> mem_we=1, mem_be=0b0011; dm_rvalid on ack with dm_rdata=0.
REQ-022 Reset in WAIT_D, mem_rvalid one cycle after rst drops -> no dm_rvalid, all outputs 0, mem_ready stall in IDLE keeps mem_req=1 with stable fields.
